inst_rom_loader: RTL
====================

# inst_rom_loader

Instruction memory for the CPU fetch port, with a byte-serial boot loader. The CPU drives a fetch address and chip enable and receives the instruction word combinationally in the same cycle; its IF/ID register captures that word. After reset the block holds the CPU in reset and accepts a big-endian byte stream into the word array. When loading finishes it releases the CPU, which then fetches from word address 0.

## Interface
Parameters:
- ADDR_W, 10: word-address width; array depth is 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ce_i  in  1  fetch chip enable, from the CPU PC stage.
- addr_i  in  32  fetch byte address from the CPU; bits [1:0] are ignored.
- inst_o  out  32  instruction word returned to the CPU.
- ld_valid_i  in  1  loader byte valid.
- ld_data_i  in  8  loader byte.
- ld_last_i  in  1  marks the final byte of the image; qualified by ld_valid_i.
- ld_ready_o  out  1  loader can accept a byte this cycle.
- ld_reload_i  in  1  one-cycle request to restart loading.
- cpu_rst_o  out  1  reset to the CPU; high while loading.
- load_words_o  out  ADDR_W+1  number of words written in the current or last load.

Reset: one clock, rst, synchronous and active-high.

## Operation
- The FSM has two states: LOAD and RUN.
  - rst forces LOAD, write pointer wptr=0, byte count bcnt=0, shift register=0, load_words_o=0.
  - Array contents are not cleared by reset.
- LOAD state:
  - ld_ready_o=1 and cpu_rst_o=1.
  - A byte is accepted when ld_valid_i && ld_ready_o.
  - Bytes are assembled big-endian: the first byte lands in [31:24], the fourth in [7:0].
  - On the 4th byte: write mem[wptr]; wptr and load_words_o increment; bcnt returns to 0.
- Accepted byte with ld_last_i=1:
  - Any unfilled low bytes of the word are zero-padded.
  - The word is written (a 0-byte partial word is impossible, because the last byte itself completes at least one byte).
  - The FSM goes to RUN.
- Array full: when the write at wptr=2^ADDR_W-1 completes, the FSM goes to RUN even without ld_last_i. No further bytes are accepted.
- RUN state: ld_ready_o=0, cpu_rst_o=0, and load_words_o is held.
- ld_reload_i:
  - In RUN: the FSM goes to LOAD, wptr=0, bcnt=0, load_words_o=0.
  - In LOAD: the same pointer and count reset; any partially assembled word is discarded.
  - A byte presented in the same cycle as ld_reload_i is dropped.
- Fetch read (combinational):
  - inst_o = mem[addr_i[ADDR_W+1:2]] when ce_i=1, cpu_rst_o=0, and addr_i[31:ADDR_W+2]==0.
  - Otherwise inst_o = 32'h0 (NOP). This covers ce_i low, out of range, and loading in progress.
- Precedence: rst > ld_reload_i > byte acceptance.

## Timing
- Reset values:
  - inst_o=0, because cpu_rst_o=1 forces it.
  - ld_ready_o=1, cpu_rst_o=1, load_words_o=0.
- Fetch latency: 0 cycles (combinational address→data). The CPU registers the word at the next edge.
- Write latency: a word is written at the edge that accepts its final byte and is readable in the following cycle.
- cpu_rst_o and ld_ready_o are decoded from the state register:
  - cpu_rst_o falls in the first cycle after the edge that writes the last word.
  - cpu_rst_o rises in the cycle after the edge that samples ld_reload_i.
- Throughput: one byte per cycle while in LOAD.
- ld_valid_i may stay high across the LOAD→RUN edge; bytes presented while ld_ready_o=0 are ignored and not counted.

## Configuration
- ROM_LOAD_CKSUM_EN defined: adds output cksum_o [31:0].
  - cksum_o is the mod-2^32 sum of every word written in the current load, including the zero-padded last word.
  - It is cleared by rst and by ld_reload_i, and updated at each write edge.
  - It is held in RUN.
- ROM_LOAD_CKSUM_EN undefined: cksum_o and its adder are absent; all other behaviour is identical.

## Test plan
- Load image:
  - Stimulus: after rst, stream 8 bytes 3C,01,00,10,34,21,00,05 with ld_last_i on byte 8.
  - Response: mem[0]=3C010010 and mem[1]=34210005; load_words_o=2; cpu_rst_o falls the cycle after byte 8.
  - Then ce_i=1 with addr_i=4 gives inst_o=34210005.
- Partial last word:
  - Stimulus: stream AA,BB,CC with last on CC.
  - Response: mem[0]=AABBCC00, load_words_o=1.
  - With ROM_LOAD_CKSUM_EN, cksum_o=AABBCC00.
- Full array:
  - Stimulus: ADDR_W=2, stream 20 bytes without ld_last_i.
  - Response: RUN entered after byte 16; load_words_o=4; bytes 17-20 are not accepted (ld_ready_o=0).
- Read gating:
  - Case: in RUN, ce_i=0. Response: inst_o=0.
  - Case: addr_i=32'h0000_1000 with ADDR_W=10. Response: inst_o=0 (out of range).
  - Case: in LOAD, any address. Response: inst_o=0.
- Reload mid-load:
  - Stimulus: after 6 bytes, pulse ld_reload_i together with a 7th byte.
  - Response: the byte is dropped, load_words_o=0, and the next 4 bytes overwrite mem[0].
- Reset mid-load:
  - Stimulus: rst during byte 2 of word 3.
  - Response: next cycle, LOAD state with load_words_o=0, cpu_rst_o=1, ld_ready_o=1; previously written words are still present in the array.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction word array for the CPU fetch port, filled by a
// byte-serial big-endian boot loader that holds the CPU in reset while loading.
// Optional feature macro: ROM_LOAD_CKSUM_EN adds cksum_o, the mod-2^32 sum of
// all words written during the current load.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting loader bytes, CPU held in reset, fetch returns NOP
// RUN   | image loaded, CPU released, fetch reads the array
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              ld_reload_i,
  output logic              cpu_rst_o,
`ifdef ROM_LOAD_CKSUM_EN
  output logic [31:0]       cksum_o,
`endif
  output logic [ADDR_W:0]   load_words_o
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W:0]   load_words_q, load_words_d;
  logic [31:0]       asm_word;
  logic              accept;
  logic              mem_we;
  logic [31:0]       mem_q [0:(2**ADDR_W)-1];

  // Byte lane bits of the fetch address are not used for word fetch.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  // Merge the incoming byte into its big-endian lane; unfilled low lanes stay zero.
  always_comb begin
    asm_word = shift_q;
    case (bcnt_q)
      2'd0:    asm_word[31:24] = ld_data_i;
      2'd1:    asm_word[23:16] = ld_data_i;
      2'd2:    asm_word[15:8]  = ld_data_i;
      default: asm_word[7:0]   = ld_data_i;
    endcase
  end

  // A byte presented together with a reload request is dropped.
  assign accept = (state_q == LOAD) && ld_valid_i && !ld_reload_i;
  assign mem_we = accept && ((bcnt_q == 2'd3) || ld_last_i);

  // Next-state and datapath update for the loader FSM.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    load_words_d = load_words_q;
    if (ld_reload_i) begin
      state_d      = LOAD;
      wptr_d       = '0;
      bcnt_d       = '0;
      shift_d      = '0;
      load_words_d = '0;
    end else if (mem_we) begin
      wptr_d       = wptr_q + ADDR_W'(1);
      bcnt_d       = '0;
      shift_d      = '0;
      load_words_d = load_words_q + (ADDR_W+1)'(1);
      if (ld_last_i || (wptr_q == {ADDR_W{1'b1}})) state_d = RUN;
    end else if (accept) begin
      bcnt_d  = bcnt_q + 2'd1;
      shift_d = asm_word;
    end
  end

  // State and loader registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      wptr_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      load_words_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      load_words_q <= load_words_d;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wptr_q] <= asm_word;
  end

`ifdef ROM_LOAD_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  // Running sum of words written in the current load.
  always_comb begin
    cksum_d = cksum_q;
    if (ld_reload_i)  cksum_d = '0;
    else if (mem_we)  cksum_d = cksum_q + asm_word;
  end

  // Checksum register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign cksum_o = cksum_q;
`endif

  assign ld_ready_o   = (state_q == LOAD);
  assign cpu_rst_o    = (state_q == LOAD);
  assign load_words_o = load_words_q;

  // Combinational fetch; NOP while loading, when disabled, or out of range.
  always_comb begin
    inst_o = 32'h0;
    if (ce_i && (state_q == RUN) && (addr_i[31:ADDR_W+2] == '0))
      inst_o = mem_q[addr_i[ADDR_W+1:2]];
  end

endmodule
